spi_seq_ctrl: RTL and testbench
===============================

// Module: spi_seq_ctrl
// PURPOSE
//  Parametrised SPI transaction sequencer for register-mapped sensors. Replays a table of INIT_LEN
//  two-byte register writes, then periodically issues a multi-byte burst read. Drives a byte-level
//  SPI engine through a start/done handshake and presents each assembled burst as one sample word.
//  Sits between the byte shifter and the sample consumer; successor to the fixed single-read fsm.
// PARAMETERS
//  INIT_LEN   2     number of init writes (0 = skip init); table supplied externally via init_idx
//  BURST_LEN  6     bytes read per sample (1..16)
//  READ_ADDR  6'h32 start register of the burst read
//  CS_GAP     2     clk cycles cs_n held high between transactions (>=1)
//  POLL_DIV   1000  clk cycles from end of one burst to start of next read command (>=CS_GAP)
// PORTS
//  clk          in   1              clock, rising edge
//  reset        in   1              asynchronous, active-high
//  enable       in   1              level; high = run sequence, low = park in IDLE
//  init_idx     out  $clog2(INIT_LEN+1)  index of current init entry
//  init_word    in   16             {reg_addr[7:0], reg_data[7:0]} for init_idx (comb lookup)
//  byte_start   out  1              one-cycle pulse: engine shifts tx_byte
//  tx_byte      out  8              byte to transmit, stable from byte_start until byte_done
//  byte_done    in   1              one-cycle pulse: byte finished, rx_byte valid this cycle
//  rx_byte      in   8              received byte
//  cs_n         out  1              chip select, active low
//  sample_data  out  8*BURST_LEN    last burst; first received byte in [7:0]
//  sample_valid out  1              one-cycle pulse when sample_data updates
//  init_done    out  1              sticky high after last init write completes
//  busy         out  1              high in any state except IDLE
// BEHAVIOUR
//  Reset: state IDLE; cs_n=1, byte_start=0, tx_byte=0, sample_data=0, sample_valid=0, init_done=0,
//   busy=0, init_idx=0, all counters 0. Reset mid-byte: cs_n rises asynchronously, no cleanup.
//  States: IDLE, GAP, INIT_ADDR, INIT_DATA, RD_CMD, RD_BYTE, POLL.
//  IDLE: enable=1 -> GAP, target INIT_ADDR if !init_done && INIT_LEN>0, else RD_CMD.
//  GAP: cs_n=1; count CS_GAP cycles, then enter target state.
//  Byte states: byte_start pulses the first cycle in the state; cs_n=0 from that cycle on; wait
//   for byte_done. Only one byte outstanding; byte_done outside a byte state is ignored.
//  INIT_ADDR: tx=init_word[15:8]; done -> INIT_DATA. INIT_DATA: tx=init_word[7:0]; on done
//   cs_n=1 next cycle; if init_idx==INIT_LEN-1: init_done<=1, target RD_CMD, else init_idx++,
//   target INIT_ADDR; -> GAP.
//  RD_CMD: tx={1'b1, (BURST_LEN>1), READ_ADDR}; done -> RD_BYTE, byte_cnt=0.
//  RD_BYTE: tx=8'h00; each done stores rx_byte at byte_cnt, byte_cnt++; done with
//   byte_cnt==BURST_LEN-1: sample_data updated and sample_valid pulses on the next cycle, -> POLL.
//  POLL: cs_n=1; count POLL_DIV cycles, then -> RD_CMD. cs_n high >= CS_GAP is guaranteed.
//  enable low: never aborts a transaction; checked only at GAP/POLL entry and in POLL -> IDLE.
//   Re-enable after init_done skips init. Partial burst data is never exposed.
//  Latency: enable rise to first byte_start = CS_GAP+2 cycles.
// STRUCTURE
//  spi_seq_pkg: state_t enum, SPI_RD_BIT/SPI_MB_BIT constants, DUMMY_BYTE=8'h00.
//  Sub-module seq_timer (load/count/expired, width $clog2(POLL_DIV+1)) shared by GAP and POLL.
//  Burst assembly is an indexed register array inside spi_seq_ctrl; no separate shifter module.
// TESTING
//  1 INIT_LEN=2, table {2D08,3101}, engine model done 8 cycles after start -> tx 2D,08,gap,31,01;
//    cs_n high exactly CS_GAP cycles between writes; init_done rises after byte 4.
//  2 After init, rx bytes 11..66 -> tx F2 then six 00; sample_data=48'h665544332211, one valid pulse.
//  3 Steady state: consecutive RD_CMD byte_starts spaced (POLL_DIV + burst time + 1) cycles; no
//    start while a byte is outstanding.
//  4 enable dropped during 3rd read byte -> burst completes, valid pulses, then IDLE, cs_n=1;
//    re-enable -> next tx is F2 (no init replay).
//  5 reset asserted mid INIT_DATA -> cs_n=1 same cycle, all outputs at reset values; on release
//    with enable=1 init replays from idx 0.
//  6 Spurious byte_done in POLL and IDLE -> no state change, sample_data unchanged.

Source files
------------

// File: rtl/spi_seq_ctrl_pkg.sv
// spi_seq_pkg: shared state encoding and SPI command-byte constants for the sensor sequencer.
package spi_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        INIT_ADDR,
        INIT_DATA,
        RD_CMD,
        RD_BYTE,
        POLL
    } state_t;

    localparam int SPI_RD_BIT = 7;
    localparam int SPI_MB_BIT = 6;
    localparam logic [7:0] DUMMY_BYTE = 8'h00;

    function automatic logic [7:0] rd_cmd(input logic mb, input logic [5:0] addr);
        logic [7:0] b;
        b = {2'b00, addr};
        b[SPI_RD_BIT] = 1'b1;
        b[SPI_MB_BIT] = mb;
        return b;
    endfunction

endpackage

// File: rtl/spi_seq_ctrl_timer.sv
// seq_timer: down-counter shared by the cs_n gap and poll interval; expired while the count is zero.
module seq_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/spi_seq_ctrl.sv
// spi_seq_ctrl: replays an init write table over a byte-level SPI engine, then polls a burst read
// and presents each completed burst as one sample word.
module spi_seq_ctrl
    import spi_seq_pkg::*;
#(
    parameter int          INIT_LEN  = 2,
    parameter int          BURST_LEN = 6,
    parameter logic [5:0]  READ_ADDR = 6'h32,
    parameter int          CS_GAP    = 2,
    parameter int          POLL_DIV  = 1000,
    localparam int         IW        = (INIT_LEN > 0) ? $clog2(INIT_LEN + 1) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    output logic [IW-1:0]          init_idx,
    input  logic [15:0]            init_word,
    output logic                   byte_start,
    output logic [7:0]             tx_byte,
    input  logic                   byte_done,
    input  logic [7:0]             rx_byte,
    output logic                   cs_n,
    output logic [8*BURST_LEN-1:0] sample_data,
    output logic                   sample_valid,
    output logic                   init_done,
    output logic                   busy
);

    localparam int TW = $clog2(POLL_DIV + 1);
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [7:0] RD_CMD_BYTE = rd_cmd(1'(BURST_LEN > 1), READ_ADDR);

    state_t                   state, target;
    logic                     enable_q;
    logic [BW-1:0]            byte_cnt;
    logic [8*BURST_LEN-1:0]   burst_q, sample_nxt;
    logic                     last_byte, timer_load, timer_exp;
    logic [TW-1:0]            timer_val;

    assign last_byte  = (byte_cnt == BW'(BURST_LEN - 1));
    assign timer_load = (state == IDLE && enable_q)
                      || (state == INIT_DATA && byte_done)
                      || (state == RD_BYTE && byte_done && last_byte);
    assign timer_val  = (state == RD_BYTE) ? TW'(POLL_DIV - 1) : TW'(CS_GAP - 1);

    // Final byte goes straight into the published word so partial bursts are never visible.
    always_comb begin
        sample_nxt = burst_q;
        sample_nxt[8*(BURST_LEN-1) +: 8] = rx_byte;
    end

    seq_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .expired  (timer_exp)
    );

    // enable is registered once, which sets the IDLE exit latency to CS_GAP+2 cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            target       <= IDLE;
            enable_q     <= 1'b0;
            init_idx     <= '0;
            byte_cnt     <= '0;
            burst_q      <= '0;
            byte_start   <= 1'b0;
            tx_byte      <= 8'h00;
            cs_n         <= 1'b1;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            init_done    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            enable_q     <= enable;
            byte_start   <= 1'b0;
            sample_valid <= 1'b0;
            case (state)
                IDLE: if (enable_q) begin
                    state  <= GAP;
                    busy   <= 1'b1;
                    target <= (!init_done && INIT_LEN > 0) ? INIT_ADDR : RD_CMD;
                end
                GAP: if (timer_exp) begin
                    state      <= target;
                    byte_start <= 1'b1;
                    cs_n       <= 1'b0;
                    tx_byte    <= (target == INIT_ADDR) ? init_word[15:8] : RD_CMD_BYTE;
                end
                INIT_ADDR: if (byte_done) begin
                    state      <= INIT_DATA;
                    byte_start <= 1'b1;
                    tx_byte    <= init_word[7:0];
                end
                INIT_DATA: if (byte_done) begin
                    cs_n  <= 1'b1;
                    state <= enable_q ? GAP : IDLE;
                    busy  <= enable_q;
                    if (init_idx == IW'(INIT_LEN - 1)) begin
                        init_done <= 1'b1;
                        target    <= RD_CMD;
                    end else begin
                        init_idx <= init_idx + 1'b1;
                        target   <= INIT_ADDR;
                    end
                end
                RD_CMD: if (byte_done) begin
                    state      <= RD_BYTE;
                    byte_cnt   <= '0;
                    byte_start <= 1'b1;
                    tx_byte    <= DUMMY_BYTE;
                end
                RD_BYTE: if (byte_done) begin
                    burst_q[8*byte_cnt +: 8] <= rx_byte;
                    if (last_byte) begin
                        sample_data  <= sample_nxt;
                        sample_valid <= 1'b1;
                        cs_n         <= 1'b1;
                        state        <= enable_q ? POLL : IDLE;
                        busy         <= enable_q;
                    end else begin
                        byte_cnt   <= byte_cnt + 1'b1;
                        byte_start <= 1'b1;
                    end
                end
                POLL: if (!enable_q) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else if (timer_exp) begin
                    state      <= RD_CMD;
                    byte_start <= 1'b1;
                    cs_n       <= 1'b0;
                    tx_byte    <= RD_CMD_BYTE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_seq_ctrl.sv
// tb_spi_seq_ctrl: directed checks of init replay, burst assembly, poll spacing, enable and reset handling
// against a byte-engine model that answers 8 cycles after each byte_start.
module tb_spi_seq_ctrl;

    localparam int INIT_LEN  = 2;
    localparam int BURST_LEN = 6;
    localparam int CS_GAP    = 2;
    localparam int POLL_DIV  = 40;
    localparam int DLY       = 8;

    logic        clk, reset, enable;
    logic [1:0]  init_idx;
    logic [15:0] init_word;
    logic        byte_start, byte_done, cs_n, sample_valid, init_done, busy;
    logic [7:0]  tx_byte, rx_byte, rx_add;
    logic [47:0] sample_data;

    int total, bad;
    int cd, idx, cyc, hi_run, overlap_err, spur_req, spur_ack, n, sz;
    logic [7:0]  tx_log[$];
    int          cmd_cyc[$];
    int          gaps[$];
    logic [47:0] saved;

    spi_seq_ctrl #(
        .INIT_LEN  (INIT_LEN),
        .BURST_LEN (BURST_LEN),
        .READ_ADDR (6'h32),
        .CS_GAP    (CS_GAP),
        .POLL_DIV  (POLL_DIV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .init_idx     (init_idx),
        .init_word    (init_word),
        .byte_start   (byte_start),
        .tx_byte      (tx_byte),
        .byte_done    (byte_done),
        .rx_byte      (rx_byte),
        .cs_n         (cs_n),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .init_done    (init_done),
        .busy         (busy)
    );

    assign init_word = (init_idx == 2'd0) ? 16'h2D08 : 16'h3101;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine model plus logging: rx byte k of a transaction is 8'h11*k + rx_add (k=0 is the command).
    initial begin
        byte_done = 1'b0; rx_byte = 8'h00;
        cd = 0; idx = 0; cyc = 0; hi_run = 0; overlap_err = 0; spur_ack = 0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            byte_done = 1'b0;
            if (reset) begin
                cd = 0;
            end else begin
                if (byte_start) begin
                    if (cd != 0) overlap_err++;
                    cd = DLY;
                    tx_log.push_back(tx_byte);
                    if (tx_byte == 8'hF2) cmd_cyc.push_back(cyc);
                end else if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        byte_done = 1'b1;
                        rx_byte = 8'(8'h11 * idx) + rx_add;
                        idx++;
                    end
                end
                if (spur_req != spur_ack && !byte_done) begin
                    byte_done = 1'b1;
                    rx_byte = 8'hEE;
                    spur_ack = spur_req;
                end
            end
            if (cs_n) begin
                hi_run++;
                idx = 0;
            end else if (hi_run > 0) begin
                gaps.push_back(hi_run);
                hi_run = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #2;
    endtask

    // sel: 0 byte_start, 1 sample_valid, 2 init_done
    task automatic wait_for(input int sel, input string tag, output int cnt);
        logic hit;
        cnt = 0;
        hit = 1'b0;
        while (!hit && cnt < 400) begin
            tick();
            cnt++;
            hit = (sel == 0) ? byte_start : (sel == 1) ? sample_valid : init_done;
        end
        if (!hit) chk({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        total = 0; bad = 0; spur_req = 0; rx_add = 8'h00;
        reset = 1'b1; enable = 1'b0;
        repeat (3) tick();
        chk("rst_cs_n", cs_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_start", byte_start, 0);
        chk("rst_tx", tx_byte, 0);
        chk("rst_sample", sample_data, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_idx", init_idx, 0);
        reset = 1'b0;
        tick();

        enable = 1'b1;
        wait_for(0, "lat0", n);
        chk("lat0", n, CS_GAP + 2);
        wait_for(2, "init_done", n);
        chk("init_bytes", tx_log.size(), 4);
        chk("init_tx0", tx_log[0], 8'h2D);
        chk("init_tx1", tx_log[1], 8'h08);
        chk("init_tx2", tx_log[2], 8'h31);
        chk("init_tx3", tx_log[3], 8'h01);
        chk("init_gap", gaps[1], CS_GAP);
        chk("init_idx_last", init_idx, 1);

        wait_for(1, "valid1", n);
        chk("sample1", sample_data, 48'h665544332211);
        chk("rd_bytes", tx_log.size(), 11);
        chk("rd_cmd", tx_log[4], 8'hF2);
        for (int i = 5; i < 11; i++) chk("rd_dummy", tx_log[i], 8'h00);
        chk("rd_gap", gaps[2], CS_GAP);
        rx_add = 8'h01;
        tick();
        chk("valid_pulse", sample_valid, 0);

        spur_req++;
        repeat (5) tick();
        chk("poll_spur_busy", busy, 1);
        chk("poll_spur_cs", cs_n, 1);
        chk("poll_spur_sample", sample_data, 48'h665544332211);
        chk("poll_spur_tx", tx_log.size(), 11);

        // 7 bytes of (DLY+1) cycles each plus POLL_DIV: 63 + 40
        wait_for(0, "cmd2", n);
        chk("cmd2_tx", tx_byte, 8'hF2);
        chk("poll_spacing", cmd_cyc[1] - cmd_cyc[0], 103);
        repeat (3) wait_for(0, "rd_byte", n);
        enable = 1'b0;
        wait_for(1, "valid2", n);
        chk("sample2", sample_data, 48'h675645342312);
        repeat (2) tick();
        chk("dis_busy", busy, 0);
        chk("dis_cs", cs_n, 1);
        sz = tx_log.size();
        repeat (60) tick();
        chk("dis_no_start", tx_log.size(), sz);
        saved = sample_data;
        spur_req++;
        repeat (3) tick();
        chk("idle_spur_busy", busy, 0);
        chk("idle_spur_sample", sample_data, saved);

        enable = 1'b1;
        wait_for(0, "lat1", n);
        chk("lat1", n, CS_GAP + 2);
        chk("reen_tx", tx_byte, 8'hF2);

        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (4) wait_for(0, "replay", n);
        chk("pre_rst_tx", tx_byte, 8'h01);
        chk("pre_rst_idx", init_idx, 1);
        repeat (3) tick();
        #3 reset = 1'b1;
        #1;
        chk("async_cs", cs_n, 1);
        chk("async_busy", busy, 0);
        chk("async_idx", init_idx, 0);
        chk("async_tx", tx_byte, 0);
        chk("async_sample", sample_data, 0);
        tick();
        reset = 1'b0;
        wait_for(0, "replay2", n);
        chk("replay_tx", tx_byte, 8'h2D);
        chk("replay_idx", init_idx, 0);
        chk("overlap", overlap_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
